// File: rtl/sc_microsequencer_if.sv
// -----------------------------------------------------------------------------
// sc_microsequencer_if
//
// Purpose:
//   Groups the signals between the microsequencer, its control-store ROM,
//   the memory handshake and the 32-bit register-file/ALU datapath.
//
// Modports:
//   master : the microsequencer side. It drives the control-store address and
//            every datapath control, and receives ROM data, the decode opcode,
//            IR bit 13, the ALU flags and memory ready.
//   slave  : the environment side (ROM + datapath + memory), the mirror of master.
//
// Signals:
//   SC_MICROSEQ_CSAddress_OutBus    control-store address
//   SC_MICROSEQ_CSData_InBus        control-store data, valid one cycle after the address
//   SC_MICROSEQ_DecodeOP_InBus      opcode from the datapath instruction register
//   SC_MICROSEQ_IR13_In             IR bit 13
//   SC_MICROSEQ_Flag*_In            ALU flags N/Z/V/C, active-high
//   SC_MICROSEQ_MemReady_In         memory ready
//   SC_MICROSEQ_Dir{A,B,C}_OutBus   register addresses
//   SC_MICROSEQ_Select{A,B,C}_Out   MIR-vs-scratchpad selects
//   SC_MICROSEQ_ALUOperation_OutBus ALU operation
//   SC_MICROSEQ_RD_Out / _WR_Out    memory read / write strobes
//   SC_MICROSEQ_PSR_OutBus          latched flags {N,Z,V,C}
// -----------------------------------------------------------------------------
interface sc_microsequencer_if #(
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_DECODEROP     = 8,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  parameter int DATAWIDTH_MICROWORD     = 41
);

  logic [DATAWIDTH_CS_ADDRESS-1:0]    SC_MICROSEQ_CSAddress_OutBus;
  logic [DATAWIDTH_MICROWORD-1:0]     SC_MICROSEQ_CSData_InBus;
  logic [DATAWIDTH_DECODEROP-1:0]     SC_MICROSEQ_DecodeOP_InBus;
  logic                               SC_MICROSEQ_IR13_In;
  logic                               SC_MICROSEQ_FlagNegative_In;
  logic                               SC_MICROSEQ_FlagZero_In;
  logic                               SC_MICROSEQ_FlagOverflow_In;
  logic                               SC_MICROSEQ_FlagCarry_In;
  logic                               SC_MICROSEQ_MemReady_In;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQ_DirA_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQ_DirB_OutBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQ_DirC_OutBus;
  logic                               SC_MICROSEQ_SelectA_Out;
  logic                               SC_MICROSEQ_SelectB_Out;
  logic                               SC_MICROSEQ_SelectC_Out;
  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_MICROSEQ_ALUOperation_OutBus;
  logic                               SC_MICROSEQ_RD_Out;
  logic                               SC_MICROSEQ_WR_Out;
  logic [3:0]                         SC_MICROSEQ_PSR_OutBus;

  modport master (
    output SC_MICROSEQ_CSAddress_OutBus,
    input  SC_MICROSEQ_CSData_InBus,
    input  SC_MICROSEQ_DecodeOP_InBus,
    input  SC_MICROSEQ_IR13_In,
    input  SC_MICROSEQ_FlagNegative_In,
    input  SC_MICROSEQ_FlagZero_In,
    input  SC_MICROSEQ_FlagOverflow_In,
    input  SC_MICROSEQ_FlagCarry_In,
    input  SC_MICROSEQ_MemReady_In,
    output SC_MICROSEQ_DirA_OutBus,
    output SC_MICROSEQ_DirB_OutBus,
    output SC_MICROSEQ_DirC_OutBus,
    output SC_MICROSEQ_SelectA_Out,
    output SC_MICROSEQ_SelectB_Out,
    output SC_MICROSEQ_SelectC_Out,
    output SC_MICROSEQ_ALUOperation_OutBus,
    output SC_MICROSEQ_RD_Out,
    output SC_MICROSEQ_WR_Out,
    output SC_MICROSEQ_PSR_OutBus
  );

  modport slave (
    input  SC_MICROSEQ_CSAddress_OutBus,
    output SC_MICROSEQ_CSData_InBus,
    output SC_MICROSEQ_DecodeOP_InBus,
    output SC_MICROSEQ_IR13_In,
    output SC_MICROSEQ_FlagNegative_In,
    output SC_MICROSEQ_FlagZero_In,
    output SC_MICROSEQ_FlagOverflow_In,
    output SC_MICROSEQ_FlagCarry_In,
    output SC_MICROSEQ_MemReady_In,
    input  SC_MICROSEQ_DirA_OutBus,
    input  SC_MICROSEQ_DirB_OutBus,
    input  SC_MICROSEQ_DirC_OutBus,
    input  SC_MICROSEQ_SelectA_Out,
    input  SC_MICROSEQ_SelectB_Out,
    input  SC_MICROSEQ_SelectC_Out,
    input  SC_MICROSEQ_ALUOperation_OutBus,
    input  SC_MICROSEQ_RD_Out,
    input  SC_MICROSEQ_WR_Out,
    input  SC_MICROSEQ_PSR_OutBus
  );

endinterface

// File: rtl/sc_microsequencer.sv
// -----------------------------------------------------------------------------
// sc_microsequencer
//
// Purpose:
//   Microprogrammed control unit for the 32-bit register-file/ALU datapath.
//   Fetches 41-bit microwords from a synchronous control-store ROM into the
//   MIR, drives the datapath controls from the MIR and sequences to the next
//   control-store address from COND, the PSR, IR bit 13 and the decode opcode.
//   Every microinstruction takes FETCH, LOAD and EXEC (plus MEMWAIT cycles
//   while a memory access waits for ready).
//
// Ports:
//   SC_MICROSEQ_CLOCK_50     in  system clock
//   SC_MICROSEQ_RESET_InLow  in  synchronous, active-low reset
//   SC_MICROSEQ_Step_In      in  single-step request (only with the macro below)
//   bus                      sc_microsequencer_if.master - ROM, datapath and
//                            memory handshake signals
//
// Microword layout, MSB first:
//   A[40:35] AMUX[34] B[33:28] BMUX[27] C[26:21] CMUX[20] RD[19] WR[18]
//   ALU[17:14] COND[13:11] JADDR[10:0]
//
// Configuration:
//   SC_MICROSEQ_SINGLESTEP_EN - when defined, adds SC_MICROSEQ_Step_In and FETCH
//   only advances in a cycle where Step_In is high. When undefined, FETCH
//   always advances.
// -----------------------------------------------------------------------------
module sc_microsequencer #(
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_DECODEROP     = 8,
  parameter int DATAWIDTH_CS_ADDRESS    = 11,
  // Must equal 3*DIR + 3 + 2 + ALU + 3 + CS_ADDRESS.
  parameter int DATAWIDTH_MICROWORD     = 41
) (
  input logic                 SC_MICROSEQ_CLOCK_50,
  input logic                 SC_MICROSEQ_RESET_InLow,
`ifdef SC_MICROSEQ_SINGLESTEP_EN
  input logic                 SC_MICROSEQ_Step_In,
`endif
  sc_microsequencer_if.master bus
);

  localparam int DIR = DATAWIDTH_MIR_DIRECTION;
  localparam int ALU = DATAWIDTH_ALU_SELECTION;
  localparam int CSW = DATAWIDTH_CS_ADDRESS;

  // Bit positions of the microword fields, built up from the LSB.
  localparam int COND_LSB = CSW;
  localparam int ALU_LSB  = COND_LSB + 3;
  localparam int WR_BIT   = ALU_LSB + ALU;
  localparam int RD_BIT   = WR_BIT + 1;
  localparam int CMUX_BIT = RD_BIT + 1;
  localparam int C_LSB    = CMUX_BIT + 1;
  localparam int BMUX_BIT = C_LSB + DIR;
  localparam int B_LSB    = BMUX_BIT + 1;
  localparam int AMUX_BIT = B_LSB + DIR;
  localparam int A_LSB    = AMUX_BIT + 1;

  localparam logic [CSW-1:0] CS_ONE = 1;

  localparam logic [2:0] COND_SEQ    = 3'd0;
  localparam logic [2:0] COND_NEG    = 3'd1;
  localparam logic [2:0] COND_ZERO   = 3'd2;
  localparam logic [2:0] COND_OVF    = 3'd3;
  localparam logic [2:0] COND_CARRY  = 3'd4;
  localparam logic [2:0] COND_IR13   = 3'd5;
  localparam logic [2:0] COND_JUMP   = 3'd6;
  localparam logic [2:0] COND_DECODE = 3'd7;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_LOAD    = 2'd1,
    ST_EXEC    = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CSW-1:0]                 cs_addr_q, cs_addr_d;
  logic [DATAWIDTH_MICROWORD-1:0] mir_q, mir_d;
  logic [3:0]                     psr_q, psr_d;

  // MIR field views
  logic [DIR-1:0] mir_a, mir_b, mir_c;
  logic           mir_amux, mir_bmux, mir_cmux;
  logic           mir_rd, mir_wr;
  logic [ALU-1:0] mir_alu;
  logic [2:0]     mir_cond;
  logic [CSW-1:0] mir_jaddr;

  assign mir_a     = mir_q[A_LSB +: DIR];
  assign mir_amux  = mir_q[AMUX_BIT];
  assign mir_b     = mir_q[B_LSB +: DIR];
  assign mir_bmux  = mir_q[BMUX_BIT];
  assign mir_c     = mir_q[C_LSB +: DIR];
  assign mir_cmux  = mir_q[CMUX_BIT];
  assign mir_rd    = mir_q[RD_BIT];
  assign mir_wr    = mir_q[WR_BIT];
  assign mir_alu   = mir_q[ALU_LSB +: ALU];
  assign mir_cond  = mir_q[COND_LSB +: 3];
  assign mir_jaddr = mir_q[CSW-1:0];

  logic       step_ok;
  logic       in_exec;
  logic       mem_op;
  logic       mem_ready;
  logic       complete;
  logic [3:0] flags_in;
  logic [CSW-1:0] next_addr;

`ifdef SC_MICROSEQ_SINGLESTEP_EN
  assign step_ok = SC_MICROSEQ_Step_In;
`else
  assign step_ok = 1'b1;
`endif

  assign mem_ready = bus.SC_MICROSEQ_MemReady_In;
  assign flags_in  = {bus.SC_MICROSEQ_FlagNegative_In, bus.SC_MICROSEQ_FlagZero_In,
                      bus.SC_MICROSEQ_FlagOverflow_In, bus.SC_MICROSEQ_FlagCarry_In};

  // EXEC and MEMWAIT both present the MIR to the datapath; the microinstruction
  // completes in EXEC when no access is pending, otherwise in the ready cycle.
  assign in_exec  = (state_q == ST_EXEC) || (state_q == ST_MEMWAIT);
  assign mem_op   = mir_rd | mir_wr;
  assign complete = ((state_q == ST_EXEC) && !(mem_op && !mem_ready)) ||
                    ((state_q == ST_MEMWAIT) && mem_ready);

  // Branch decision uses psr_q, i.e. the flags latched before this cycle's
  // own PSR update.
  always_comb begin
    next_addr = cs_addr_q + CS_ONE;
    case (mir_cond)
      COND_SEQ:    next_addr = cs_addr_q + CS_ONE;
      COND_NEG:    if (psr_q[3]) next_addr = mir_jaddr;
      COND_ZERO:   if (psr_q[2]) next_addr = mir_jaddr;
      COND_OVF:    if (psr_q[1]) next_addr = mir_jaddr;
      COND_CARRY:  if (psr_q[0]) next_addr = mir_jaddr;
      COND_IR13:   if (bus.SC_MICROSEQ_IR13_In) next_addr = mir_jaddr;
      COND_JUMP:   next_addr = mir_jaddr;
      COND_DECODE: next_addr = {1'b1, bus.SC_MICROSEQ_DecodeOP_InBus, 2'b00};
      default:     next_addr = cs_addr_q + CS_ONE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cs_addr_d = cs_addr_q;
    mir_d     = mir_q;
    psr_d     = psr_q;
    case (state_q)
      ST_FETCH: begin
        if (step_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        mir_d   = bus.SC_MICROSEQ_CSData_InBus;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (mem_op && !mem_ready) state_d = ST_MEMWAIT;
        else                      state_d = ST_FETCH;
      end
      ST_MEMWAIT: begin
        if (mem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Only the flag-setting ALU ops (ANDCC/ORCC/NORCC/ADDCC, top two bits 00)
    // update the PSR.
    if (complete) begin
      cs_addr_d = next_addr;
      if (mir_alu[ALU-1 -: 2] == 2'b00) psr_d = flags_in;
    end
  end

  always_ff @(posedge SC_MICROSEQ_CLOCK_50) begin
    if (!SC_MICROSEQ_RESET_InLow) begin
      state_q   <= ST_FETCH;
      cs_addr_q <= '0;
      mir_q     <= '0;
      psr_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cs_addr_q <= cs_addr_d;
      mir_q     <= mir_d;
      psr_q     <= psr_d;
    end
  end

  // DirC/SelectC are only live in the completing cycle: the datapath writes
  // every cycle and register 0 is the non-writable sink. WR yields to RD.
  assign bus.SC_MICROSEQ_CSAddress_OutBus    = cs_addr_q;
  assign bus.SC_MICROSEQ_DirA_OutBus         = in_exec ? mir_a : '0;
  assign bus.SC_MICROSEQ_DirB_OutBus         = in_exec ? mir_b : '0;
  assign bus.SC_MICROSEQ_SelectA_Out         = in_exec & mir_amux;
  assign bus.SC_MICROSEQ_SelectB_Out         = in_exec & mir_bmux;
  assign bus.SC_MICROSEQ_ALUOperation_OutBus = in_exec ? mir_alu : '0;
  assign bus.SC_MICROSEQ_DirC_OutBus         = complete ? mir_c : '0;
  assign bus.SC_MICROSEQ_SelectC_Out         = complete & mir_cmux;
  assign bus.SC_MICROSEQ_RD_Out              = in_exec & mir_rd;
  assign bus.SC_MICROSEQ_WR_Out              = in_exec & mir_wr & ~mir_rd;
  assign bus.SC_MICROSEQ_PSR_OutBus          = psr_q;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Self-checking bench for sc_microsequencer. A microinstruction-level model
// walks the ROM program: for each microword it knows the cycle sequence
// (fetch, load, optional memory wait cycles, completion), the outputs expected
// in each of those cycles, and the next address / PSR from the branch rules.
module tb_sc_microsequencer;

  logic clk = 1'b0;
  logic rstN = 1'b0;
`ifdef SC_MICROSEQ_SINGLESTEP_EN
  logic stepIn = 1'b0;
`endif

  always #5 clk = ~clk;

  sc_microsequencer_if bus ();

  sc_microsequencer dut (
    .SC_MICROSEQ_CLOCK_50    (clk),
    .SC_MICROSEQ_RESET_InLow (rstN),
`ifdef SC_MICROSEQ_SINGLESTEP_EN
    .SC_MICROSEQ_Step_In     (stepIn),
`endif
    .bus                     (bus.master)
  );

  // Synchronous control-store ROM: data valid one cycle after the address.
  logic [40:0] rom [0:2047];
  always @(posedge clk) bus.SC_MICROSEQ_CSData_InBus <= rom[bus.SC_MICROSEQ_CSAddress_OutBus];

  int nChecks = 0;
  int nErrors = 0;
  int mPc = 0;
  logic [3:0] mPsr = 4'h0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] packOut(input logic [10:0] cs, input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] c, input logic sa, input logic sb, input logic sc,
                                          input logic [3:0] alu, input logic rd, input logic wr,
                                          input logic [3:0] psr);
    return {22'd0, cs, a, b, c, sa, sb, sc, alu, rd, wr, psr};
  endfunction

  function automatic logic [63:0] dutOut();
    return packOut(bus.SC_MICROSEQ_CSAddress_OutBus, bus.SC_MICROSEQ_DirA_OutBus, bus.SC_MICROSEQ_DirB_OutBus,
                   bus.SC_MICROSEQ_DirC_OutBus, bus.SC_MICROSEQ_SelectA_Out, bus.SC_MICROSEQ_SelectB_Out,
                   bus.SC_MICROSEQ_SelectC_Out, bus.SC_MICROSEQ_ALUOperation_OutBus, bus.SC_MICROSEQ_RD_Out,
                   bus.SC_MICROSEQ_WR_Out, bus.SC_MICROSEQ_PSR_OutBus);
  endfunction

  function automatic logic [40:0] mkWord(input int a, input int amux, input int b, input int bmux,
                                         input int c, input int cmux, input int rd, input int wr,
                                         input int alu, input int cond, input int jaddr);
    return {6'(a), 1'(amux), 6'(b), 1'(bmux), 6'(c), 1'(cmux), 1'(rd), 1'(wr), 4'(alu), 3'(cond), 11'(jaddr)};
  endfunction

  // Outputs while a microword is being executed; done selects the completing cycle.
  function automatic logic [63:0] expExec(input int pc, input logic [40:0] w, input logic done,
                                          input logic [3:0] psr);
    logic [5:0] c;
    logic sc;
    c  = done ? w[26:21] : 6'd0;
    sc = done ? w[20] : 1'b0;
    return packOut(11'(pc), w[40:35], w[33:28], c, w[34], w[27], sc, w[17:14], w[19], w[18] & ~w[19], psr);
  endfunction

  function automatic int nextPc(input int pc, input logic [40:0] w, input logic [3:0] psr,
                                input logic [7:0] dec, input logic ir13);
    int cond;
    int j;
    int seq;
    cond = int'(w[13:11]);
    j    = int'(w[10:0]);
    seq  = (pc + 1) % 2048;
    case (cond)
      0: return seq;
      1, 2, 3, 4: return psr[4 - cond] ? j : seq;
      5: return ir13 ? j : seq;
      6: return j;
      default: return 1024 + int'(dec) * 4;
    endcase
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveNoise();
    {bus.SC_MICROSEQ_FlagNegative_In, bus.SC_MICROSEQ_FlagZero_In,
     bus.SC_MICROSEQ_FlagOverflow_In, bus.SC_MICROSEQ_FlagCarry_In} = 4'($urandom);
    bus.SC_MICROSEQ_MemReady_In = 1'($urandom);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    stepCycle();
    stepCycle();
    #1;
    checkOutput("reset", dutOut(), 64'd0);
    rstN = 1'b1;
    mPc  = 0;
    mPsr = 4'h0;
  endtask

  // Runs one whole microinstruction starting in its FETCH cycle; flagsDone are
  // the flags presented in the completing cycle, waits the number of cycles
  // memory stays not-ready (ignored when the word does no access).
  task automatic applyStimulus(input logic [3:0] flagsDone, input logic [7:0] dec, input logic ir13,
                               input int waits);
    logic [40:0] w;
    logic [63:0] idleExp;
    int n;
    w = rom[mPc];
    bus.SC_MICROSEQ_DecodeOP_InBus = dec;
    bus.SC_MICROSEQ_IR13_In = ir13;
    idleExp = packOut(11'(mPc), 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mPsr);
`ifdef SC_MICROSEQ_SINGLESTEP_EN
    stepIn = 1'b0;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      driveNoise();
      #1;
      checkOutput("idle", dutOut(), idleExp);
      stepCycle();
    end
    stepIn = 1'b1;
`endif
    driveNoise();
    #1;
    checkOutput("fetch", dutOut(), idleExp);
    stepCycle();
`ifdef SC_MICROSEQ_SINGLESTEP_EN
    stepIn = 1'b0;
`endif
    driveNoise();
    #1;
    checkOutput("load", dutOut(), idleExp);
    stepCycle();
    n = (w[19] | w[18]) ? waits : 0;
    for (int k = 0; k < n; k++) begin
      driveNoise();
      bus.SC_MICROSEQ_MemReady_In = 1'b0;
      #1;
      checkOutput("wait", dutOut(), expExec(mPc, w, 1'b0, mPsr));
      stepCycle();
    end
    driveNoise();
    if (w[19] | w[18]) bus.SC_MICROSEQ_MemReady_In = 1'b1;
    {bus.SC_MICROSEQ_FlagNegative_In, bus.SC_MICROSEQ_FlagZero_In,
     bus.SC_MICROSEQ_FlagOverflow_In, bus.SC_MICROSEQ_FlagCarry_In} = flagsDone;
    #1;
    checkOutput("done", dutOut(), expExec(mPc, w, 1'b1, mPsr));
    mPc = nextPc(mPc, w, mPsr, dec, ir13);
    if (w[17:16] == 2'b00) mPsr = flagsDone;
    stepCycle();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [40:0] w1;
    bus.SC_MICROSEQ_DecodeOP_InBus = 8'h00;
    bus.SC_MICROSEQ_IR13_In = 1'b0;
    bus.SC_MICROSEQ_MemReady_In = 1'b0;
    {bus.SC_MICROSEQ_FlagNegative_In, bus.SC_MICROSEQ_FlagZero_In,
     bus.SC_MICROSEQ_FlagOverflow_In, bus.SC_MICROSEQ_FlagCarry_In} = 4'h0;
    for (int i = 0; i < 2048; i++) rom[i] = 41'd0;

    // NOP program: sequential addresses 0, 1, 2.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(4'($urandom), 8'($urandom), 1'($urandom), 0);
    checkOutput("nopSeq", 64'(bus.SC_MICROSEQ_CSAddress_OutBus), 64'd3);

    // Flag-setting op then a branch on Z.
    rom[0] = mkWord(1, 0, 2, 0, 5, 0, 0, 0, 4'b0011, 0, 0);
    rom[1] = mkWord(3, 1, 4, 1, 0, 0, 0, 0, 4'b1000, 2, 11'h040);
    doReset();
    applyStimulus(4'b0101, 8'h00, 1'b0, 0);
    applyStimulus(4'b1010, 8'h00, 1'b0, 0);
    checkOutput("jumpZ", 64'(bus.SC_MICROSEQ_CSAddress_OutBus), 64'h040);
    checkOutput("psrHeld", 64'(bus.SC_MICROSEQ_PSR_OutBus), 64'h5);

    // Decode dispatch.
    rom[0] = mkWord(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 7, 0);
    doReset();
    applyStimulus(4'h0, 8'h9A, 1'b0, 0);
    checkOutput("decode", 64'(bus.SC_MICROSEQ_CSAddress_OutBus), 64'h668);

    // Read with three not-ready cycles.
    rom[0] = mkWord(7, 0, 9, 0, 8, 1, 1, 0, 4'b0100, 0, 0);
    doReset();
    applyStimulus(4'h0, 8'h00, 1'b0, 3);
    checkOutput("afterWait", 64'(bus.SC_MICROSEQ_CSAddress_OutBus), 64'd1);

    // Wrap from 2047, then RD+WR together.
    rom[0]    = mkWord(0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 6, 2047);
    rom[2047] = mkWord(0, 0, 0, 0, 2, 0, 0, 0, 4'b1000, 0, 0);
    doReset();
    applyStimulus(4'h0, 8'h00, 1'b0, 0);
    applyStimulus(4'h0, 8'h00, 1'b0, 0);
    checkOutput("wrap", 64'(bus.SC_MICROSEQ_CSAddress_OutBus), 64'd0);
    rom[0] = mkWord(1, 0, 1, 0, 1, 0, 1, 1, 4'b1000, 0, 0);
    applyStimulus(4'h0, 8'h00, 1'b0, 0);

    // Reset in the middle of a memory wait aborts the access.
    rom[0] = mkWord(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    rom[1] = mkWord(2, 1, 3, 0, 4, 1, 1, 0, 4'b0100, 0, 0);
    w1 = rom[1];
    doReset();
    applyStimulus(4'hF, 8'h00, 1'b0, 0);
`ifdef SC_MICROSEQ_SINGLESTEP_EN
    stepIn = 1'b1;
`endif
    bus.SC_MICROSEQ_MemReady_In = 1'b0;
    #1;
    checkOutput("abFetch", dutOut(), packOut(11'd1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'hF));
    stepCycle();
`ifdef SC_MICROSEQ_SINGLESTEP_EN
    stepIn = 1'b0;
`endif
    stepCycle();
    bus.SC_MICROSEQ_MemReady_In = 1'b0;
    #1;
    checkOutput("abExec", dutOut(), expExec(1, w1, 1'b0, 4'hF));
    stepCycle();
    bus.SC_MICROSEQ_MemReady_In = 1'b0;
    #1;
    checkOutput("abWait", dutOut(), expExec(1, w1, 1'b0, 4'hF));
    rstN = 1'b0;
    stepCycle();
    #1;
    checkOutput("abort", dutOut(), 64'd0);
    rstN = 1'b1;
    mPc  = 0;
    mPsr = 4'h0;
    applyStimulus(4'h3, 8'h00, 1'b0, 0);

`ifdef SC_MICROSEQ_SINGLESTEP_EN
    // Without a step request FETCH never advances.
    doReset();
    stepIn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      checkOutput("noStep", dutOut(), 64'd0);
    end
`endif

    // Random program.
    for (int i = 0; i < 2048; i++) rom[i] = 41'({$urandom, $urandom});
    doReset();
    for (int i = 0; i < 250; i++)
      applyStimulus(4'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/sc_microsequencer.md
Name: sc_microsequencer

Overview:
- Control unit that sits directly upstream of the 32-bit register-file/ALU datapath and drives all of its control inputs.
- Fetches 41-bit microwords from an external synchronous control-store ROM into a Microinstruction Register (MIR), then drives the datapath A/B/C addresses, mux selects, ALU operation and memory RD/WR from the MIR.
- Computes the next control-store address from the COND field, the processor status flags, IR bit 13 and the decode opcode returned by the datapath.
- Holds the current microinstruction while a memory access is waiting on its ready handshake.

Parameters:
- DATAWIDTH_MIR_DIRECTION, 6, width of the A/B/C register address fields.
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU operation field.
- DATAWIDTH_DECODEROP, 8, width of the decode opcode from the datapath.
- DATAWIDTH_CS_ADDRESS, 11, width of the control-store address.
- DATAWIDTH_MICROWORD, 41, microword width; must equal 3*DIR + 3 + 2 + ALU + 3 + CS_ADDRESS.

Ports:
- SC_MICROSEQ_CLOCK_50  in  1  system clock.
- SC_MICROSEQ_RESET_InLow  in  1  reset, synchronous, active-low.
- SC_MICROSEQ_CSData_InBus  in  41  control-store data; valid one cycle after the address.
- SC_MICROSEQ_DecodeOP_InBus  in  8  opcode from the datapath instruction register.
- SC_MICROSEQ_IR13_In  in  1  IR bit 13 from the datapath.
- SC_MICROSEQ_FlagNegative_In, _FlagZero_In, _FlagOverflow_In, _FlagCarry_In  in  1 each  ALU flags, active-high.
- SC_MICROSEQ_MemReady_In  in  1  memory ready.
- SC_MICROSEQ_CSAddress_OutBus  out  11  control-store address.
- SC_MICROSEQ_DirA_OutBus, _DirB_OutBus, _DirC_OutBus  out  6 each  register addresses to the datapath.
- SC_MICROSEQ_SelectA_Out, _SelectB_Out, _SelectC_Out  out  1 each  MIR-vs-scratchpad selects.
- SC_MICROSEQ_ALUOperation_OutBus  out  4  ALU operation.
- SC_MICROSEQ_RD_Out, SC_MICROSEQ_WR_Out  out  1 each  memory read / write strobes.
- SC_MICROSEQ_PSR_OutBus  out  4  latched flags {N,Z,V,C}.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset, checked only at the clock edge, has priority over every other event:
  - State goes to FETCH; CS address register and MIR go to 0; PSR goes to 4'b0000.
  - All outputs read 0.
  - A reset asserted during MEMWAIT aborts the access: RD/WR drop on the next cycle.
- Microword layout, MSB first: A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20], RD[19], WR[18], ALU[17:14], COND[13:11], JADDR[10:0].
- FSM, minimum 3 cycles per microinstruction:
  - FETCH: drive the CS address. Go to LOAD.
  - LOAD: MIR <= CSData_InBus. Go to EXEC.
  - EXEC: drive the MIR fields.
    - If RD|WR is set and MemReady_In=0, go to MEMWAIT.
    - Otherwise the microinstruction completes this cycle; go to FETCH with the next address.
  - MEMWAIT: MIR and all outputs held. When MemReady_In=1 the microinstruction completes; go to FETCH.
- Outputs by state:
  - A/B/ALU/SelectA/SelectB follow the MIR in EXEC and MEMWAIT; they are 0 in FETCH and LOAD.
  - DirC and SelectC carry the MIR value only in the completing cycle and are 0 otherwise. The datapath loads every cycle and address 0 is non-writable.
  - RD/WR equal MIR.RD/WR throughout EXEC and MEMWAIT, including the completing cycle; they are 0 in FETCH and LOAD.
  - If RD and WR are both set, WR is suppressed and RD is honoured.
- PSR: in the completing cycle, if ALU[3:2]==2'b00 (ANDCC/ORCC/NORCC/ADDCC), PSR <= {N,Z,V,C} inputs. Otherwise PSR is held.
- Next address, evaluated in the completing cycle using the PSR value from before that cycle's update:
  - COND 0: CS+1.
  - COND 1/2/3/4: JADDR if PSR N/Z/V/C respectively is set, else CS+1.
  - COND 5: JADDR if IR13, else CS+1.
  - COND 6: JADDR.
  - COND 7: {1'b1, DecodeOP, 2'b00}.
- CS+1 wraps from 2047 to 0.

Optional Feature:
- Macro: SC_MICROSEQ_SINGLESTEP_EN.
- When defined:
  - Adds input SC_MICROSEQ_Step_In (1 bit).
  - FETCH advances to LOAD only in a cycle where Step_In=1; otherwise it stays in FETCH with outputs 0.
  - The step request is level-sensitive; the bench pulses it for 1 cycle.
- When undefined: no extra port, and FETCH always advances.

Test Plan:
- Reset held low for 2 cycles, then released with ROM[0]=COND 0 NOP → CSAddress = 0, 1, 2 issued every 3 cycles; all datapath outputs 0 in FETCH and LOAD.
- ROM[0] has ALU=0011, C=5, CMUX=0 with flags N=0 Z=1 V=0 C=1; ROM[1] has COND=2, JADDR=0x40 → PSR becomes 4'b0101; DirC=5 for exactly 1 cycle; next address after ROM[1] is 0x40.
- ROM[0] has COND=7 with DecodeOP=8'h9A → next CSAddress = 11'h668.
- ROM[0] has RD=1, C=8 with MemReady low for 3 cycles → RD high for 4 cycles; DirC=8 only in the ready cycle; next FETCH follows the ready cycle.
- ROM[2047] has COND=0 → next address 0; ROM[x] with RD=WR=1 and MemReady=1 in EXEC → RD=1, WR=0 for 1 cycle.
- Reset pulled low during MEMWAIT → next cycle FETCH, CSAddress=0, RD=0, PSR=0; with SC_MICROSEQ_SINGLESTEP_EN defined and Step_In low, the FSM stays in FETCH indefinitely.
